// File: rtl/matmul_pkg.sv
// matmul_pkg: shared sizes, latencies, sequencer states and config check for the matmul sequencer
package matmul_pkg;

    localparam int DIM        = 64;
    localparam int IN_AW      = 6;
    localparam int OUT_AW     = 12;
    localparam int MEM_RD_LAT = 1;
    localparam int TREE_LAT   = 7;
    localparam int LAT        = MEM_RD_LAT + TREE_LAT;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    // A tile dimension is usable when it is 1..DIM
    function automatic logic cfg_ok(input logic [IN_AW:0] n);
        return (n != '0) && (n <= (IN_AW+1)'(DIM));
    endfunction

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// matmul_seq_ctrl_if: PS handshake, config and memory-port bundle of the matmul sequencer
interface matmul_seq_ctrl_if;

    logic                          start;
    logic                          abort;
    logic [matmul_pkg::IN_AW:0]    cfg_rows;
    logic [matmul_pkg::IN_AW:0]    cfg_cols;
    logic                          en_a;
    logic [matmul_pkg::IN_AW-1:0]  addr_a;
    logic                          en_b;
    logic [matmul_pkg::IN_AW-1:0]  addr_b;
    logic                          en_out;
    logic                          we_out;
    logic [matmul_pkg::OUT_AW-1:0] addr_out;
    logic                          busy;
    logic                          done;
    logic                          cfg_err;

    modport master (
        output start, abort, cfg_rows, cfg_cols,
        input  en_a, addr_a, en_b, addr_b, en_out, we_out, addr_out, busy, done, cfg_err
    );

    modport slave (
        input  start, abort, cfg_rows, cfg_cols,
        output en_a, addr_a, en_b, addr_b, en_out, we_out, addr_out, busy, done, cfg_err
    );

endinterface

// File: rtl/matmul_valid_delay.sv
// matmul_valid_delay: LAT-deep valid+address shift line aligning output writes with the tree result
module matmul_valid_delay
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [OUT_AW-1:0] addr_i,
    output logic              valid_o,
    output logic              pending_o,
    output logic [OUT_AW-1:0] addr_o
);

    logic [LAT-1:0]    vld_q;
    logic [OUT_AW-1:0] adr_q [LAT];

    // Shift one stage per clock; invalid slots carry address 0 so addr_o is 0 whenever valid_o is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < LAT; k++) adr_q[k] <= '0;
        end else if (flush_i) begin
            vld_q <= '0;
            for (int k = 0; k < LAT; k++) adr_q[k] <= '0;
        end else begin
            vld_q    <= {vld_q[LAT-2:0], valid_i};
            adr_q[0] <= valid_i ? addr_i : '0;
            for (int k = 1; k < LAT; k++) adr_q[k] <= adr_q[k-1];
        end
    end

    assign valid_o   = vld_q[LAT-1];
    assign addr_o    = adr_q[LAT-1];
    assign pending_o = |vld_q[LAT-2:0];

endmodule

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: walks all (i, j) pairs of a tile, drives A/B reads and delayed output writes
module matmul_seq_ctrl
    import matmul_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    matmul_seq_ctrl_if.slave bus
);

    state_t             state_q;
    logic [IN_AW-1:0]   i_q, j_q, last_i_q, last_j_q;
    logic               en_q, busy_q, done_q, cfg_err_q;
    logic               wr_valid, pending, flush, last_j;
    logic [OUT_AW-1:0]  wr_addr;

    assign last_j = j_q == last_j_q;
    assign flush  = bus.abort && (state_q == ISSUE || state_q == DRAIN);

    // Sequencer FSM with i/j counters; all handshake and read-port outputs are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            last_i_q  <= '0;
            last_j_q  <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        if (cfg_ok(bus.cfg_rows) && cfg_ok(bus.cfg_cols)) begin
                            last_i_q <= IN_AW'(bus.cfg_rows - (IN_AW+1)'(1));
                            last_j_q <= IN_AW'(bus.cfg_cols - (IN_AW+1)'(1));
                            i_q      <= '0;
                            j_q      <= '0;
                            en_q     <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= ISSUE;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.abort) begin
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (last_j && i_q == last_i_q) begin
                        en_q    <= 1'b0;
                        state_q <= DRAIN;
                    end else if (last_j) begin
                        j_q <= '0;
                        i_q <= i_q + IN_AW'(1);
                    end else begin
                        j_q <= j_q + IN_AW'(1);
                    end
                end
                DRAIN: begin
                    if (bus.abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (!pending) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    matmul_valid_delay u_delay (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush),
        .valid_i   (en_q),
        .addr_i    ({i_q, j_q}),
        .valid_o   (wr_valid),
        .pending_o (pending),
        .addr_o    (wr_addr)
    );

    assign bus.en_a     = en_q;
    assign bus.en_b     = en_q;
    assign bus.addr_a   = i_q;
    assign bus.addr_b   = j_q;
    assign bus.we_out   = wr_valid;
    assign bus.en_out   = wr_valid;
    assign bus.addr_out = wr_addr;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb_matmul_seq_ctrl: directed scenarios for the matmul sequencer with hand-computed cycle/address expectations
module tb_matmul_seq_ctrl;
    import matmul_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    matmul_seq_ctrl_if bus();

    matmul_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int pcount = 0;
    int base   = 0;
    int passed = 0;
    int total  = 0;
    int viol   = 0;
    int busy_hi = 0;
    int w_addr[$];
    int w_cyc[$];
    int i_addr[$];
    int i_cyc[$];
    int d_cyc[$];
    int e_cyc[$];

    // Cycle index relative to the cycle in which start was driven (cycle 0)
    always @(posedge clk) pcount <= pcount + 1;

    // Log every output event at the falling edge, away from the active edge
    always @(negedge clk) begin
        if (bus.we_out)  begin w_addr.push_back(int'(bus.addr_out)); w_cyc.push_back(pcount - base); end
        if (bus.en_a)    begin i_addr.push_back(int'(bus.addr_a) * DIM + int'(bus.addr_b)); i_cyc.push_back(pcount - base); end
        if (bus.done)    d_cyc.push_back(pcount - base);
        if (bus.cfg_err) e_cyc.push_back(pcount - base);
        if (bus.busy)    busy_hi++;
        if (bus.en_out !== bus.we_out || bus.en_b !== bus.en_a || (!bus.we_out && bus.addr_out !== '0)) viol++;
    end

    task automatic clear_logs();
        w_addr.delete(); w_cyc.delete(); i_addr.delete(); i_cyc.delete();
        d_cyc.delete(); e_cyc.delete(); busy_hi = 0;
    endtask

    task automatic go(input int r, input int c);
        @(negedge clk);
        clear_logs();
        bus.cfg_rows = (IN_AW+1)'(r);
        bus.cfg_cols = (IN_AW+1)'(c);
        bus.start = 1'b1;
        base = pcount;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            #1;
            if (d_cyc.size() > 0) ok = 1'b1;
        end
        total++;
        if (!ok) $display("FAIL %s_done_timeout: no done within %0d cycles", name, budget);
        else passed++;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_rows = '0; bus.cfg_cols = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.en_a, bus.en_b, bus.we_out, bus.en_out, bus.busy, bus.done, bus.cfg_err} !== 7'b0)
            $display("FAIL reset_flags: got %b want 0000000",
                     {bus.en_a, bus.en_b, bus.we_out, bus.en_out, bus.busy, bus.done, bus.cfg_err});
        else passed++;
        total++;
        if ({bus.addr_a, bus.addr_b, bus.addr_out} !== 24'h0)
            $display("FAIL reset_addrs: got %h want 000000", {bus.addr_a, bus.addr_b, bus.addr_out});
        else passed++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        go(1, 1);
        wait_done(40, "single");
        total++;
        if (w_addr.size() != 1) $display("FAIL single_nwrites: got %0d want 1", w_addr.size()); else passed++;
        total++;
        if ((w_cyc.size() > 0 ? w_cyc[0] : -1) != 9 || (w_addr.size() > 0 ? w_addr[0] : -1) != 0)
            $display("FAIL single_write: got cyc %0d addr %0d want cyc 9 addr 0",
                     w_cyc.size() > 0 ? w_cyc[0] : -1, w_addr.size() > 0 ? w_addr[0] : -1);
        else passed++;
        total++;
        if ((d_cyc.size() > 0 ? d_cyc[0] : -1) != 10)
            $display("FAIL single_done_cyc: got %0d want 10", d_cyc.size() > 0 ? d_cyc[0] : -1);
        else passed++;
        total++;
        if (bus.busy !== 1'b0) $display("FAIL single_busy_at_done: got %b want 0", bus.busy); else passed++;
    endtask

    task automatic test_3x5();
        int errs = 0;
        go(3, 5);
        wait_done(60, "t3x5");
        total++;
        if (w_addr.size() != 15) $display("FAIL t3x5_nwrites: got %0d want 15", w_addr.size()); else passed++;
        for (int k = 0; k < w_addr.size() && k < 15; k++)
            if (w_addr[k] != (k / 5) * 64 + k % 5 || w_cyc[k] != 9 + k) errs++;
        total++;
        if (errs != 0) $display("FAIL t3x5_sequence: got %0d bad writes want 0", errs); else passed++;
        errs = 0;
        if (i_addr.size() != w_addr.size()) errs++;
        for (int k = 0; k < i_addr.size() && k < w_addr.size(); k++)
            if (i_addr[k] != w_addr[k] || i_cyc[k] + 8 != w_cyc[k]) errs++;
        total++;
        if (errs != 0) $display("FAIL t3x5_issue_align: got %0d misaligned want 0", errs); else passed++;
        total++;
        if ((d_cyc.size() > 0 ? d_cyc[0] : -1) != 24)
            $display("FAIL t3x5_done_cyc: got %0d want 24", d_cyc.size() > 0 ? d_cyc[0] : -1);
        else passed++;
        total++;
        if (busy_hi != 23) $display("FAIL t3x5_busy_cycles: got %0d want 23", busy_hi); else passed++;
    endtask

    task automatic test_full();
        int errs = 0;
        go(64, 64);
        wait_done(4200, "full");
        total++;
        if (w_addr.size() != 4096) $display("FAIL full_nwrites: got %0d want 4096", w_addr.size()); else passed++;
        for (int k = 0; k < w_addr.size() && k < 4096; k++)
            if (w_addr[k] != k || w_cyc[k] != 9 + k) errs++;
        total++;
        if (errs != 0) $display("FAIL full_sequence: got %0d bad writes want 0", errs); else passed++;
        total++;
        if ((w_cyc.size() > 0 ? w_cyc[0] : -1) != 9)
            $display("FAIL full_first_write: got %0d want 9", w_cyc.size() > 0 ? w_cyc[0] : -1);
        else passed++;
        total++;
        if ((d_cyc.size() > 0 ? d_cyc[0] : -1) != 4105)
            $display("FAIL full_done_cyc: got %0d want 4105", d_cyc.size() > 0 ? d_cyc[0] : -1);
        else passed++;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0 || busy_hi != 4104)
            $display("FAIL full_busy: got busy %b cycles %0d want busy 0 cycles 4104", bus.busy, busy_hi);
        else passed++;
    endtask

    task automatic test_cfg_err(input int r, input int c, input string name);
        go(r, c);
        repeat (6) @(negedge clk);
        #1;
        total++;
        if (e_cyc.size() != 1 || e_cyc[0] != 1)
            $display("FAIL %s_cfg_err: got %0d pulses first %0d want 1 pulse at 1", name,
                     e_cyc.size(), e_cyc.size() > 0 ? e_cyc[0] : -1);
        else passed++;
        total++;
        if (i_cyc.size() + w_cyc.size() + busy_hi + d_cyc.size() != 0)
            $display("FAIL %s_no_activity: got issues %0d writes %0d busy %0d done %0d want all 0", name,
                     i_cyc.size(), w_cyc.size(), busy_hi, d_cyc.size());
        else passed++;
    endtask

    task automatic test_abort();
        go(8, 32);
        for (int n = 0; n < 200 && pcount - base < 100; n++) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.en_a, bus.we_out} !== 3'b000)
            $display("FAIL abort_outputs: got busy/en_a/we_out %b want 000", {bus.busy, bus.en_a, bus.we_out});
        else passed++;
        repeat (20) @(negedge clk);
        #1;
        total++;
        if (i_cyc.size() != 100) $display("FAIL abort_issues: got %0d want 100", i_cyc.size()); else passed++;
        total++;
        if (w_cyc.size() != 92 || (w_cyc.size() > 0 ? w_cyc[w_cyc.size()-1] : -1) != 100)
            $display("FAIL abort_writes: got %0d last %0d want 92 last 100", w_cyc.size(),
                     w_cyc.size() > 0 ? w_cyc[w_cyc.size()-1] : -1);
        else passed++;
        total++;
        if (d_cyc.size() != 0) $display("FAIL abort_no_done: got %0d want 0", d_cyc.size()); else passed++;
        go(2, 2);
        wait_done(40, "abort_restart");
        total++;
        if (w_addr.size() != 4 || (d_cyc.size() > 0 ? d_cyc[0] : -1) != 13 || w_addr[w_addr.size()-1] != 65)
            $display("FAIL abort_restart: got %0d writes done %0d want 4 writes done 13 last 65",
                     w_addr.size(), d_cyc.size() > 0 ? d_cyc[0] : -1);
        else passed++;
    endtask

    task automatic test_back_to_back();
        go(2, 3);
        bus.cfg_rows = 7'd1;
        bus.cfg_cols = 7'd1;
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        wait_done(40, "b2b");
        total++;
        if ((d_cyc.size() > 0 ? d_cyc[0] : -1) != 15)
            $display("FAIL b2b_done_cyc: got %0d want 15", d_cyc.size() > 0 ? d_cyc[0] : -1);
        else passed++;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        total++;
        if (d_cyc.size() != 1 || w_addr.size() != 6 || i_addr.size() != 6)
            $display("FAIL b2b_ignored_starts: got done %0d writes %0d issues %0d want 1 6 6",
                     d_cyc.size(), w_addr.size(), i_addr.size());
        else passed++;
    endtask

    task automatic test_rst_drain();
        go(2, 2);
        for (int n = 0; n < 50 && pcount - base < 7; n++) @(negedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b1 || bus.en_a !== 1'b0)
            $display("FAIL drain_state: got busy %b en_a %b want busy 1 en_a 0", bus.busy, bus.en_a);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({bus.en_a, bus.we_out, bus.busy, bus.done, bus.cfg_err, bus.addr_a, bus.addr_b, bus.addr_out} !== '0)
            $display("FAIL rst_drain_outputs: got busy %b we_out %b addr_a %0d addr_b %0d addr_out %0d want all 0",
                     bus.busy, bus.we_out, bus.addr_a, bus.addr_b, bus.addr_out);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        go(1, 1);
        wait_done(40, "after_rst");
        total++;
        if ((d_cyc.size() > 0 ? d_cyc[0] : -1) != 10 || w_addr.size() != 1)
            $display("FAIL after_rst_run: got done %0d writes %0d want done 10 writes 1",
                     d_cyc.size() > 0 ? d_cyc[0] : -1, w_addr.size());
        else passed++;
    endtask

    task automatic test_invariants();
        total++;
        if (viol != 0) $display("FAIL port_invariants: got %0d bad cycles want 0", viol); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_3x5();
        test_full();
        test_cfg_err(0, 4, "rows0");
        test_cfg_err(4, 65, "cols65");
        test_abort();
        test_back_to_back();
        test_rst_drain();
        test_invariants();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
